// File: rtl/fpu_result_writeback.sv
// Result memory written by the FPU through valid/ready, with auto-incrementing write pointer and FSM clear sweep.
// Define FPU_WB_WRAP_EN to let writes continue circularly once the memory is full.
module fpu_result_writeback #(
   parameter int DEPTH  = 8192,
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_result,
   input  logic [4:0]        in_flags,
   input  logic [ADDR_W-1:0] in_tag,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [127:0]      rd_data,
   output logic [CNT_W-1:0]  wr_count,
   output logic              full,
   output logic              wrapped
);

   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state, state_nxt;
   logic [127:0]        mem [DEPTH];
   logic [127:0]        entry;
   logic [ADDR_W-1:0]   wr_ptr, clear_ptr;
   logic                accept, clr_last, wrap_en;

`ifdef FPU_WB_WRAP_EN
   assign wrap_en = 1'b1;
`else
   assign wrap_en = 1'b0;
`endif

   assign full     = (wr_count == FULL_CNT);
   assign clr_last = (state == CLEAR) && (clear_ptr == LAST);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_nxt  = state;
      clear_busy = 1'b0;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            // a clear request wins over a result offered in the same cycle
            in_ready = !clear_req && (!full || wrap_en);
            if (clear_req) state_nxt = CLEAR;
         end
         CLEAR: begin
            clear_busy = 1'b1;
            if (clr_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         wr_count  <= '0;
         clear_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (clr_last) begin
            wr_ptr    <= '0;
            wr_count  <= '0;
            clear_ptr <= '0;
         end else if (state == CLEAR) begin
            clear_ptr <= clear_ptr + 1'b1;
         end
         if (accept) begin
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (wr_count != FULL_CNT) wr_count <= wr_count + 1'b1;
         end
      end
   end

`ifdef FPU_WB_WRAP_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                         wrapped <= 1'b0;
      else if (clr_last)                  wrapped <= 1'b0;
      else if (accept && wr_ptr == LAST)  wrapped <= 1'b1;
   end
`else
   assign wrapped = 1'b0;
`endif

   always_comb begin
      entry                   = '0;
      entry[127:64]           = in_result;
      entry[63 -: ADDR_W]     = in_tag;
      entry[4:0]              = in_flags;
   end

   // The clear write ignores reset so the entry being swept when reset lands is still zeroed.
   always_ff @(posedge clk) begin
      if (state == CLEAR)        mem[clear_ptr[IDX_W-1:0]] <= '0;
      else if (accept && rst_n)  mem[wr_ptr[IDX_W-1:0]]    <= entry;
   end

   assign rd_data = ({1'b0, rd_addr} < DEPTH_X) ? mem[rd_addr[IDX_W-1:0]] : '0;

endmodule
